pulse_divider_bank: RTL

- Multi-channel, runtime-programmable slow clock/strobe generator; the parametrised successor to the fixed-COUNT single-pulse divider.
- Each channel emits a one-cycle `pulse` every DIV cycles plus a duty-cycle clock `sclk`.
- Divisor and duty are loaded per channel through a valid/ready config port. A loaded value takes effect glitch-free at the next period boundary.
- A global `sync` phase-aligns all channels. Feeds DAC SPI timing, stage step clocks and sampling strobes.

---
 rtl/pulse_divider_pkg.sv | 17 +
 rtl/pulse_divider_bank_if.sv | 20 ++
 rtl/pulse_divider_channel.sv | 86 ++++++++
 rtl/pulse_divider_bank.sv | 53 +++++
 4 files changed

// File: rtl/pulse_divider_pkg.sv
// Shared constants, config record and divisor clamp for the pulse divider bank.
package pulse_divider_pkg;

  localparam int PKG_WIDTH = 16;
  localparam int DIV_MIN   = 2;

  typedef struct packed {
    logic [PKG_WIDTH-1:0] div;
    logic [PKG_WIDTH-1:0] duty;
  } cfg_t;

  // Divisors below DIV_MIN cannot form a period with a distinct terminal count.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/pulse_divider_bank_if.sv
// Configuration port of the pulse divider bank: per-channel divisor/duty loads.
interface pulse_divider_bank_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  // Handshake: a transfer happens on every rising clk edge where cfg_valid and
  // cfg_ready are both high. The master holds cfg_ch/cfg_div/cfg_duty stable while
  // cfg_valid is high; cfg_ready depends combinationally on cfg_ch only.
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_duty;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_duty, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_duty, output cfg_ready);

endinterface

// File: rtl/pulse_divider_channel.sv
// One divider channel: phase counter, active/shadow config and registered strobes.
module pulse_divider_channel #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
  input  logic [WIDTH-1:0] load_duty,
  output logic             pending,
  output logic             pulse,
  output logic             sclk
);

  typedef struct packed {
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] duty;
  } ch_cfg_t;

  localparam ch_cfg_t RESET_CFG = '{div: WIDTH'(DEFAULT_DIV), duty: WIDTH'(DEFAULT_DIV / 2)};

  logic [WIDTH-1:0] cnt, cnt_d;
  logic             run, run_d;
  logic             pending_d;
  logic             tc;
  ch_cfg_t          active, active_d;
  ch_cfg_t          shadow, shadow_d;

  assign tc = run && (cnt == active.div - WIDTH'(1));

  always_comb begin
    run_d     = enable;
    cnt_d     = cnt;
    active_d  = active;
    shadow_d  = shadow;
    pending_d = pending;
    if (!enable) begin
      cnt_d = '0;
      if (pending) begin
        active_d  = shadow;
        pending_d = 1'b0;
      end
    end else if (!run || sync || tc) begin
      // Start, restart or wrap: every one of these is a period boundary.
      cnt_d = '0;
      if (pending) begin
        active_d  = shadow;
        pending_d = 1'b0;
      end
    end else begin
      cnt_d = cnt + WIDTH'(1);
    end
    if (load) begin
      if (!run || !enable || tc) begin
        active_d = {load_div, load_duty};
      end else begin
        shadow_d  = {load_div, load_duty};
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      run     <= 1'b0;
      active  <= RESET_CFG;
      shadow  <= '0;
      pending <= 1'b0;
      pulse   <= 1'b0;
      sclk    <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      run     <= run_d;
      active  <= active_d;
      shadow  <= shadow_d;
      pending <= pending_d;
      pulse   <= run_d && (cnt_d == '0);
      sclk    <= run_d && (cnt_d < active_d.duty);
    end
  end

endmodule

// File: rtl/pulse_divider_bank.sv
// Bank of NCH runtime-programmable strobe/slow-clock dividers sharing one config port.
module pulse_divider_bank
  import pulse_divider_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 25
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       enable,
  input  logic                 sync,
  pulse_divider_bank_if.slave  cfg,
  output logic [NCH-1:0]       pulse,
  output logic [NCH-1:0]       sclk
);

  localparam int             CHW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW:0]   NCH_LIM = (CHW + 1)'(NCH);

  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   load;
  logic             ch_in_range;
  logic             accept;
  logic [WIDTH-1:0] div_clamped;

  // Out-of-range channels always accept so a stray write cannot stall the port.
  assign ch_in_range   = {1'b0, cfg.cfg_ch} < NCH_LIM;
  assign cfg.cfg_ready = !ch_in_range || !pending[cfg.cfg_ch];
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign div_clamped   = WIDTH'(clamp_div(32'(cfg.cfg_div)));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign load[i] = accept && ch_in_range && (cfg.cfg_ch == CHW'(i));

    pulse_divider_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable[i]),
      .sync      (sync),
      .load      (load[i]),
      .load_div  (div_clamped),
      .load_duty (cfg.cfg_duty),
      .pending   (pending[i]),
      .pulse     (pulse[i]),
      .sclk      (sclk[i])
    );
  end

endmodule
